// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The requester drives start/bin; the converter returns busy/done/bcd/blank.
interface bin_to_bcd_seq_if;
  logic        start;
  logic [9:0]  bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  blank;

  modport master (
    output start, bin,
    input  busy, done, bcd, blank
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, blank
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// 10-bit binary to 4-digit BCD, shift-add-3, one bit per clock.
// Result and leading-zero mask update only on the done edge.
module bin_to_bcd_seq (
  input  logic         CLK,
  input  logic         RSTn,
  bin_to_bcd_seq_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  shreg;
  logic [15:0] scratch;
  logic [15:0] adj;
  logic [15:0] scr_nxt;
  logic [3:0]  step;
  logic        last;
  logic [15:0] bcd_q;
  logic [3:0]  blank_q;
  logic [3:0]  blank_nxt;
  logic        done_q;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    adj[15:12] = add3(scratch[15:12]);
    adj[11:8]  = add3(scratch[11:8]);
    adj[7:4]   = add3(scratch[7:4]);
    adj[3:0]   = add3(scratch[3:0]);
    scr_nxt    = (adj << 1) | {15'd0, shreg[9]};
    last       = (step == 4'd9);
  end

  always_comb begin
    blank_nxt[3] = (scr_nxt[15:12] == 4'd0);
    blank_nxt[2] = blank_nxt[3] & (scr_nxt[11:8] == 4'd0);
    blank_nxt[1] = blank_nxt[2] & (scr_nxt[7:4] == 4'd0);
    blank_nxt[0] = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE):  if (bus.start) state_nxt = SHIFT;
      (state == SHIFT): if (last) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      step    <= '0;
      bcd_q   <= '0;
      blank_q <= 4'b1110;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      if (state == IDLE && bus.start) begin
        shreg   <= bus.bin;
        scratch <= '0;
        step    <= '0;
      end else if (state == SHIFT) begin
        scratch <= scr_nxt;
        shreg   <= {shreg[8:0], 1'b0};
        step    <= step + 4'd1;
        // Final step: publish the shifted value, not the pre-step one
        if (last) begin
          bcd_q   <= scr_nxt;
          blank_q <= blank_nxt;
          done_q  <= 1'b1;
          step    <= '0;
        end
      end
    end
  end

  assign bus.busy  = (state == SHIFT);
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.blank = blank_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases, random values,
// abort/ignore scenarios and a full 0..1023 sweep with start held high.
module tb_bin_to_bcd_seq;
  logic CLK;
  logic RSTn;
  int   n_cmp;
  int   n_bad;
  logic [15:0] last_exp;

  bin_to_bcd_seq_if bif ();

  bin_to_bcd_seq dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [3:0] ref_blank(input int v);
    return {v < 1000, v < 100, v < 10, 1'b0};
  endfunction

  function automatic logic nib_ok(input logic [15:0] b);
    return (b[15:12] <= 4'd1) && (b[11:8] <= 4'd9) &&
           (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  task automatic conv(input int v, input string tag);
    int k;
    int nb;
    logic [15:0] mid;
    bif.bin   = 10'(v);
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    bif.bin   = 10'($urandom_range(0, 1023));
    chk({tag, "_busy"}, 32'(bif.busy), 32'd1);
    k   = 0;
    nb  = 1;
    mid = 16'hxxxx;
    while (!bif.done && k < 30) begin
      if (k == 4) mid = bif.bcd;
      tick();
      k++;
      if (bif.busy) nb++;
    end
    chk({tag, "_lat"}, 32'(k), 32'd10);
    chk({tag, "_nbusy"}, 32'(nb), 32'd10);
    chk({tag, "_hold"}, 32'(mid), 32'(last_exp));
    chk({tag, "_bcd"}, 32'(bif.bcd), 32'(ref_bcd(v)));
    chk({tag, "_blank"}, 32'(bif.blank), 32'(ref_blank(v)));
    chk({tag, "_busy0"}, 32'(bif.busy), 32'd0);
    last_exp = ref_bcd(v);
    tick();
    chk({tag, "_done1"}, 32'(bif.done), 32'd0);
  endtask

  initial begin
    int k;
    int nd;
    logic seen;
    n_cmp     = 0;
    n_bad     = 0;
    last_exp  = 16'h0000;
    RSTn      = 1'b0;
    bif.start = 1'b0;
    bif.bin   = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_done", 32'(bif.done), 32'd0);
    chk("rst_bcd", 32'(bif.bcd), 32'h0000);
    chk("rst_blank", 32'(bif.blank), 32'b1110);
    RSTn = 1'b1;
    tick();

    conv(0, "zero");
    conv(1023, "max");
    conv(999, "n999");
    conv(42, "n42");
    repeat (20) conv(int'($urandom_range(0, 1023)), "rnd");

    // Second start during conversion must be ignored
    bif.bin   = 10'd500;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    repeat (3) tick();
    bif.bin   = 10'd7;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    bif.bin   = '0;
    k = 4;
    while (!bif.done && k < 30) begin
      tick();
      k++;
    end
    chk("ign_lat", 32'(k), 32'd10);
    chk("ign_bcd", 32'(bif.bcd), 32'h0500);
    nd = 0;
    repeat (15) begin
      tick();
      if (bif.done) nd++;
    end
    chk("ign_ndone", 32'(nd), 32'd0);
    last_exp = 16'h0500;

    // Reset mid-conversion aborts with no done
    bif.bin   = 10'd777;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen |= bif.done;
    end
    RSTn = 1'b0;
    tick();
    chk("abt_seen", 32'(seen), 32'd0);
    chk("abt_busy", 32'(bif.busy), 32'd0);
    chk("abt_done", 32'(bif.done), 32'd0);
    chk("abt_bcd", 32'(bif.bcd), 32'h0000);
    chk("abt_blank", 32'(bif.blank), 32'b1110);
    bif.start = 1'b1;
    tick();
    chk("rst_prio", 32'(bif.busy), 32'd0);
    bif.start = 1'b0;
    RSTn = 1'b1;
    last_exp = 16'h0000;
    tick();
    chk("post_rst_idle", 32'(bif.busy), 32'd0);
    conv(777, "re777");

    // Exhaustive sweep, start held high: one result every 11 cycles
    bif.start = 1'b1;
    for (int v = 0; v < 1024; v++) begin
      bif.bin = 10'(v);
      tick();
      bif.bin = 10'($urandom_range(0, 1023));
      k = 1;
      while (!bif.done && k < 30) begin
        tick();
        k++;
      end
      chk("sw_period", 32'(k), 32'd11);
      chk("sw_bcd", 32'(bif.bcd), 32'(ref_bcd(v)));
      chk("sw_blank", 32'(bif.blank), 32'(ref_blank(v)));
      chk("sw_nib", 32'(nib_ok(bif.bcd)), 32'd1);
    end
    bif.start = 1'b0;
    tick();
    tick();
    chk("end_idle", 32'(bif.busy), 32'd0);
    chk("end_hold", 32'(bif.bcd), 32'h1023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
